pito_irq_ctrl: RTL and testbench
================================

# pito_irq_ctrl

Per-hart interrupt pending/arbitration stage feeding the pito CSR/trap unit. Collects external, software, timer and MVU interrupt sources for all barrel harts, keeps per-hart MIP state and masks it with each hart's MIE/mstatus.MIE. For the hart about to issue, it presents the highest-priority enabled interrupt as a ready-made mcause value one cycle later. Also owns the shared mtime counter and per-hart mtimecmp.

## Interface
- NUM_HARTS, 8, number of barrel harts
- HART_CNT_WIDTH, $clog2(NUM_HARTS), hart index width
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- hart_sel  in  HART_CNT_WIDTH  hart issuing next cycle (barrel counter)
- ext_irq  in  NUM_HARTS  asynchronous external interrupt level, one per hart
- mvu_irq  in  NUM_HARTS  MVU done pulse/level, one per hart (synchronous)
- sw_set / sw_clr  in  1 / 1  software interrupt set / clear strobe
- sw_hart  in  HART_CNT_WIDTH  target hart of sw_set/sw_clr
- csr_mie  in  NUM_HARTS*32  per-hart MIE, hart h at [32h+31:32h]
- csr_mstatus_mie  in  NUM_HARTS  per-hart global enable
- irq_ack  in  1  trap entered for irq_ack_hart
- irq_ack_hart  in  HART_CNT_WIDTH  hart that took the trap
- irq_ack_code  in  5  interrupt code taken (3, 7, 11, 16)
- cmp_we  in  1  mtimecmp write strobe
- cmp_hart  in  HART_CNT_WIDTH  mtimecmp target hart
- cmp_hi  in  1  1 = write upper word, 0 = lower word
- cmp_wdata  in  32  mtimecmp write data
- irq_valid  out  1  enabled interrupt pending for irq_hart
- irq_hart  out  HART_CNT_WIDTH  hart_sel delayed one cycle
- irq_cause  out  32  mcause value, (1<<31)|code
- csr_mip  out  32  MIP of irq_hart (bits 3, 7, 11, 16 only)
- mtime  out  64  shared machine timer

## Operation
- MEIP[h]: ext_irq[h] through a 2-flop synchronizer; level-sensitive; not cleared by ack.
- MSIP[h]: sticky; set by sw_set when sw_hart==h; cleared by sw_clr or by an ack with code 3.
- MVIP[h]: rising edge of mvu_irq[h] (1-cycle registered prior value) sets sticky bit; cleared by an ack with code 16.
- MTIP[h]: level, mtime >= mtimecmp[h], unsigned 64-bit compare.
- Same-cycle set and clear on one sticky bit: set wins. An ack for a level source (7, 11) is accepted and ignored.
- Acks for one hart never affect another hart.
- Take condition for hart h: csr_mstatus_mie[h] & |(MIP[h] & mie[h]).
- Priority when several are enabled: 11 (MEI) > 3 (MSI) > 7 (MTI) > 16 (MVU).
- mtime increments by 1 every cycle and wraps 2^64-1 -> 0.
- cmp_we writes the selected 32-bit half of mtimecmp[cmp_hart]. The other half is unchanged.
- Reset: all pending bits 0, synchronizers 0, mtime 0, every mtimecmp = all ones. Outputs irq_valid=0, irq_hart=0, irq_cause=0, csr_mip=0.
- Reset asserted mid-operation clears all state immediately (asynchronous). The first evaluation happens on the first clk edge after release.

## Timing
- hart_sel sampled at edge N. irq_valid/irq_hart/irq_cause/csr_mip are registered and valid after edge N+1, computed from MIP/MIE state as of edge N.
- When irq_valid=0, irq_cause is 0.
- ext_irq to MEIP latency: 2 cycles. mvu_irq edge to MVIP: 1 cycle. sw_set to MSIP: 1 cycle.
- MTIP follows mtime/mtimecmp registers combinationally, then is registered into the outputs.
- An ack at edge N clears the bit at edge N. A hart_sel for that hart sampled at the same edge sees the pre-clear value. The CSR unit must not re-take within one barrel round; no extra protection is provided.

## Configuration
- PITO_IRQ_TIMER_EN defined: mtime, mtimecmp and MTIP are implemented as above.
- PITO_IRQ_TIMER_EN undefined:
  - no mtime or mtimecmp storage is implemented;
  - MTIP is constant 0 and mtime outputs 0;
  - cmp_we writes are ignored;
  - priority order of the remaining sources is unchanged.

## Test plan
- Reset, then hart_sel=0..7 with no sources -> irq_valid=0, irq_cause=0, csr_mip=0, mtime counts 0,1,2...
- sw_set, sw_hart=2; all MIE bits set, mstatus_mie[2]=1; hart_sel=2 -> next cycle irq_valid=1, irq_hart=2, irq_cause=32'h8000_0003. Ack code 3 -> later irq_valid=0.
- mvu_irq[5] pulses while ext_irq[5]=1 for 3+ cycles, MIE bits 11 and 16 set; hart_sel=5 -> cause 32'h8000_000B first. Drop ext_irq, wait 2 cycles -> cause 32'h8000_0010 until ack code 16.
- mtimecmp[1] = {hi=0, lo=20}, MIE bit 7 set; sample hart 1 -> irq_valid=0 while mtime<20, 32'h8000_0007 once mtime>=20. Rewrite lo=all ones -> cleared.
- MIP nonzero but csr_mstatus_mie[h]=0 -> irq_valid=0 while csr_mip still shows pending bits. Same-cycle sw_set and ack code 3 on one hart -> MSIP remains 1.
- Build without PITO_IRQ_TIMER_EN: mtime stays 0; cmp write with lo=0 -> no cause 7 ever asserted.

Source files
------------

// File: rtl/pito_irq_ctrl.sv
// Per-hart interrupt pending/arbitration stage for the pito barrel core.
// Optional shared mtime/mtimecmp timer is built only when PITO_IRQ_TIMER_EN is defined.
module pito_irq_ctrl #(
    parameter int NUM_HARTS      = 8,
    parameter int HART_CNT_WIDTH = $clog2(NUM_HARTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [HART_CNT_WIDTH-1:0]   hart_sel,
    input  logic [NUM_HARTS-1:0]        ext_irq,
    input  logic [NUM_HARTS-1:0]        mvu_irq,
    input  logic                        sw_set,
    input  logic                        sw_clr,
    input  logic [HART_CNT_WIDTH-1:0]   sw_hart,
    input  logic [NUM_HARTS*32-1:0]     csr_mie,
    input  logic [NUM_HARTS-1:0]        csr_mstatus_mie,
    input  logic                        irq_ack,
    input  logic [HART_CNT_WIDTH-1:0]   irq_ack_hart,
    input  logic [4:0]                  irq_ack_code,
    input  logic                        cmp_we,
    input  logic [HART_CNT_WIDTH-1:0]   cmp_hart,
    input  logic                        cmp_hi,
    input  logic [31:0]                 cmp_wdata,
    output logic                        irq_valid,
    output logic [HART_CNT_WIDTH-1:0]   irq_hart,
    output logic [31:0]                 irq_cause,
    output logic [31:0]                 csr_mip,
    output logic [63:0]                 mtime
);
    localparam logic [4:0] CODE_MSI = 5'd3;
    localparam logic [4:0] CODE_MTI = 5'd7;
    localparam logic [4:0] CODE_MEI = 5'd11;
    localparam logic [4:0] CODE_MVU = 5'd16;

    logic [NUM_HARTS-1:0] ext_s1_q, ext_s2_q;
    logic [NUM_HARTS-1:0] msip_q, msip_d;
    logic [NUM_HARTS-1:0] mvip_q, mvip_d;
    logic [NUM_HARTS-1:0] mvu_prev_q;
    logic [NUM_HARTS-1:0] mtip;

    logic                      irq_valid_q, irq_valid_d;
    logic [HART_CNT_WIDTH-1:0] irq_hart_q;
    logic [31:0]               irq_cause_q, irq_cause_d;
    logic [31:0]               csr_mip_q, csr_mip_d;

    // Sticky bits: clear sources first, set last so a same-cycle set wins.
    always_comb begin
        msip_d = msip_q;
        mvip_d = mvip_q;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (irq_ack && irq_ack_hart == HART_CNT_WIDTH'(h) && irq_ack_code == CODE_MSI)
                msip_d[h] = 1'b0;
            if (sw_clr && sw_hart == HART_CNT_WIDTH'(h))
                msip_d[h] = 1'b0;
            if (sw_set && sw_hart == HART_CNT_WIDTH'(h))
                msip_d[h] = 1'b1;
            if (irq_ack && irq_ack_hart == HART_CNT_WIDTH'(h) && irq_ack_code == CODE_MVU)
                mvip_d[h] = 1'b0;
            if (mvu_irq[h] && !mvu_prev_q[h])
                mvip_d[h] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_s1_q   <= '0;
            ext_s2_q   <= '0;
            msip_q     <= '0;
            mvip_q     <= '0;
            mvu_prev_q <= '0;
        end else begin
            ext_s1_q   <= ext_irq;
            ext_s2_q   <= ext_s1_q;
            msip_q     <= msip_d;
            mvip_q     <= mvip_d;
            mvu_prev_q <= mvu_irq;
        end
    end

`ifdef PITO_IRQ_TIMER_EN
    logic [63:0] mtime_q;
    logic [63:0] mtimecmp_q [NUM_HARTS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_q <= '0;
            for (int h = 0; h < NUM_HARTS; h++)
                mtimecmp_q[h] <= '1;
        end else begin
            mtime_q <= mtime_q + 64'd1;
            if (cmp_we) begin
                if (cmp_hi)
                    mtimecmp_q[cmp_hart][63:32] <= cmp_wdata;
                else
                    mtimecmp_q[cmp_hart][31:0] <= cmp_wdata;
            end
        end
    end

    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++)
            mtip[h] = (mtime_q >= mtimecmp_q[h]);
    end

    assign mtime = mtime_q;
`else
    logic unused_cmp;
    assign unused_cmp = ^{cmp_we, cmp_hart, cmp_hi, cmp_wdata};
    assign mtip  = '0;
    assign mtime = '0;
`endif

    // Arbitration for the hart issuing next cycle, from pre-update state.
    logic [NUM_HARTS-1:0][31:0] mie_arr;
    logic [31:0]                mie_sel;
    logic [3:0]                 en;
    logic                       unused_mie;

    assign mie_arr    = csr_mie;
    assign mie_sel    = mie_arr[hart_sel];
    assign unused_mie = ^mie_sel;

    always_comb begin
        csr_mip_d     = '0;
        csr_mip_d[3]  = msip_q[hart_sel];
        csr_mip_d[7]  = mtip[hart_sel];
        csr_mip_d[11] = ext_s2_q[hart_sel];
        csr_mip_d[16] = mvip_q[hart_sel];
        en = {csr_mip_d[16] & mie_sel[16], csr_mip_d[11] & mie_sel[11],
              csr_mip_d[7]  & mie_sel[7],  csr_mip_d[3]  & mie_sel[3]};
        irq_valid_d = csr_mstatus_mie[hart_sel] & (|en);
        irq_cause_d = '0;
        if (irq_valid_d) begin
            if (en[2])
                irq_cause_d = {1'b1, 26'd0, CODE_MEI};
            else if (en[0])
                irq_cause_d = {1'b1, 26'd0, CODE_MSI};
            else if (en[1])
                irq_cause_d = {1'b1, 26'd0, CODE_MTI};
            else
                irq_cause_d = {1'b1, 26'd0, CODE_MVU};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_valid_q <= 1'b0;
            irq_hart_q  <= '0;
            irq_cause_q <= '0;
            csr_mip_q   <= '0;
        end else begin
            irq_valid_q <= irq_valid_d;
            irq_hart_q  <= hart_sel;
            irq_cause_q <= irq_cause_d;
            csr_mip_q   <= csr_mip_d;
        end
    end

    assign irq_valid = irq_valid_q;
    assign irq_hart  = irq_hart_q;
    assign irq_cause = irq_cause_q;
    assign csr_mip   = csr_mip_q;
endmodule

// File: tb/tb_pito_irq_ctrl.sv
// Self-checking bench for pito_irq_ctrl: directed scenarios plus random traffic
// against a rule-level reference model (timer checks follow PITO_IRQ_TIMER_EN).
module tb_pito_irq_ctrl;
  localparam int NH = 8;
  localparam int PRIO [4] = '{11, 3, 7, 16};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] hart_sel = '0;
  logic [NH-1:0] ext_irq = '0, mvu_irq = '0;
  logic sw_set = 0, sw_clr = 0;
  logic [2:0] sw_hart = '0;
  logic [NH*32-1:0] csr_mie = '0;
  logic [NH-1:0] csr_mstatus_mie = '0;
  logic irq_ack = 0;
  logic [2:0] irq_ack_hart = '0;
  logic [4:0] irq_ack_code = '0;
  logic cmp_we = 0, cmp_hi = 0;
  logic [2:0] cmp_hart = '0;
  logic [31:0] cmp_wdata = '0;
  logic irq_valid;
  logic [2:0] irq_hart;
  logic [31:0] irq_cause, csr_mip;
  logic [63:0] mtime;

  int total = 0;
  int bad = 0;

  pito_irq_ctrl #(.NUM_HARTS(NH)) dut (
    .clk(clk), .rst(rst), .hart_sel(hart_sel), .ext_irq(ext_irq), .mvu_irq(mvu_irq),
    .sw_set(sw_set), .sw_clr(sw_clr), .sw_hart(sw_hart), .csr_mie(csr_mie),
    .csr_mstatus_mie(csr_mstatus_mie), .irq_ack(irq_ack), .irq_ack_hart(irq_ack_hart),
    .irq_ack_code(irq_ack_code), .cmp_we(cmp_we), .cmp_hart(cmp_hart), .cmp_hi(cmp_hi),
    .cmp_wdata(cmp_wdata), .irq_valid(irq_valid), .irq_hart(irq_hart),
    .irq_cause(irq_cause), .csr_mip(csr_mip), .mtime(mtime)
  );

  // clock
  always #5 clk = ~clk;

  // reference model: pending bits per hart, evaluated from the rules
  logic [NH-1:0] m_s1, m_s2, m_msip, m_mvip, m_mvprev;
  logic [63:0] m_mtime;
  logic [63:0] m_cmp [NH];
  logic m_valid;
  logic [2:0] m_hart;
  logic [31:0] m_cause, m_mip, m_en;

  function automatic logic [31:0] pend(int h);
    logic [31:0] w;
    w = '0;
    w[3] = m_msip[h];
    w[11] = m_s2[h];
    w[16] = m_mvip[h];
`ifdef PITO_IRQ_TIMER_EN
    w[7] = (m_mtime >= m_cmp[h]);
`endif
    return w;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_msip = '0; m_mvip = '0; m_mvprev = '0; m_mtime = '0;
      for (int h = 0; h < NH; h++) m_cmp[h] = '1;
      m_valid = 0; m_hart = '0; m_cause = '0; m_mip = '0;
    end else begin
      m_mip = pend(int'(hart_sel));
      m_en = m_mip & csr_mie[int'(hart_sel)*32 +: 32];
      m_hart = hart_sel;
      m_valid = csr_mstatus_mie[hart_sel] && (m_en != 0);
      m_cause = '0;
      if (m_valid)
        for (int i = 3; i >= 0; i--)
          if (m_en[PRIO[i]]) m_cause = 32'h8000_0000 | 32'(PRIO[i]);
      for (int h = 0; h < NH; h++) begin
        if ((sw_clr && sw_hart == 3'(h)) || (irq_ack && irq_ack_hart == 3'(h) && irq_ack_code == 5'd3))
          m_msip[h] = 1'b0;
        if (sw_set && sw_hart == 3'(h)) m_msip[h] = 1'b1;
        if (irq_ack && irq_ack_hart == 3'(h) && irq_ack_code == 5'd16) m_mvip[h] = 1'b0;
        if (mvu_irq[h] && !m_mvprev[h]) m_mvip[h] = 1'b1;
      end
      m_mvprev = mvu_irq;
      m_s2 = m_s1;
      m_s1 = ext_irq;
`ifdef PITO_IRQ_TIMER_EN
      m_mtime = m_mtime + 64'd1;
      if (cmp_we) begin
        if (cmp_hi) m_cmp[cmp_hart][63:32] = cmp_wdata;
        else m_cmp[cmp_hart][31:0] = cmp_wdata;
      end
`endif
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sw_set = 0; sw_clr = 0; irq_ack = 0; cmp_we = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    repeat (2) cyc();
    total++;
    if ({irq_valid, irq_hart, irq_cause, csr_mip} !== '0 || mtime !== 64'd0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%0b h=%0d c=%h mip=%h mtime=%0d want all 0",
               irq_valid, irq_hart, irq_cause, csr_mip, mtime);
    end
    @(negedge clk) rst = 0;
    for (int i = 0; i < NH; i++) begin
      hart_sel = 3'(i);
      cyc();
      total++;
      if (irq_valid !== 1'b0 || irq_cause !== 32'd0 || csr_mip !== 32'd0) begin
        bad++;
        $display("FAIL idle_hart%0d: got v=%0b c=%h mip=%h want 0/0/0", i, irq_valid, irq_cause, csr_mip);
      end
      total++;
`ifdef PITO_IRQ_TIMER_EN
      if (mtime !== 64'(i + 1)) begin
`else
      if (mtime !== 64'd0) begin
`endif
        bad++;
        $display("FAIL idle_mtime: got %0d at step %0d", mtime, i);
      end
    end
  endtask

  task automatic test_sw();
    csr_mie = '1; csr_mstatus_mie = '1;
    hart_sel = 3'd2; sw_set = 1; sw_hart = 3'd2;
    cyc();
    sw_set = 0;
    cyc();
    total++;
    if (irq_valid !== 1'b1 || irq_hart !== 3'd2 || irq_cause !== 32'h8000_0003) begin
      bad++;
      $display("FAIL sw_take: got v=%0b h=%0d c=%h want 1/2/80000003", irq_valid, irq_hart, irq_cause);
    end
    irq_ack = 1; irq_ack_hart = 3'd2; irq_ack_code = 5'd3;
    cyc();
    total++;
    if (irq_valid !== 1'b1) begin
      bad++;
      $display("FAIL sw_ack_same_edge: got v=%0b want 1", irq_valid);
    end
    idle();
    cyc();
    total++;
    if (irq_valid !== 1'b0 || irq_cause !== 32'd0) begin
      bad++;
      $display("FAIL sw_cleared: got v=%0b c=%h want 0/0", irq_valid, irq_cause);
    end
  endtask

  task automatic test_mvu_ext();
    csr_mie[5*32 +: 32] = 32'h0001_0800;
    hart_sel = 3'd5; ext_irq[5] = 1; mvu_irq[5] = 1;
    cyc();
    mvu_irq[5] = 0;
    repeat (3) cyc();
    total++;
    if (irq_valid !== 1'b1 || irq_cause !== 32'h8000_000B || csr_mip !== 32'h0001_0800) begin
      bad++;
      $display("FAIL mei_over_mvu: got v=%0b c=%h mip=%h want 1/8000000b/00010800", irq_valid, irq_cause, csr_mip);
    end
    ext_irq[5] = 0;
    repeat (3) cyc();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (irq_valid !== 1'b1 || irq_cause !== 32'h8000_0010) begin
        bad++;
        $display("FAIL mvu_held%0d: got v=%0b c=%h want 1/80000010", i, irq_valid, irq_cause);
      end
      cyc();
    end
    irq_ack = 1; irq_ack_hart = 3'd5; irq_ack_code = 5'd16;
    cyc();
    idle();
    cyc();
    total++;
    if (irq_valid !== 1'b0 || csr_mip !== 32'd0) begin
      bad++;
      $display("FAIL mvu_acked: got v=%0b mip=%h want 0/0", irq_valid, csr_mip);
    end
  endtask

  task automatic test_mask();
    csr_mie = '1; csr_mstatus_mie = 8'hEF;
    hart_sel = 3'd4; sw_set = 1; sw_hart = 3'd4;
    cyc();
    idle();
    cyc();
    total++;
    if (irq_valid !== 1'b0 || csr_mip !== 32'h0000_0008 || irq_cause !== 32'd0) begin
      bad++;
      $display("FAIL global_mask: got v=%0b mip=%h c=%h want 0/00000008/0", irq_valid, csr_mip, irq_cause);
    end
    sw_set = 1; sw_hart = 3'd4; irq_ack = 1; irq_ack_hart = 3'd4; irq_ack_code = 5'd3;
    cyc();
    idle();
    cyc();
    total++;
    if (csr_mip[3] !== 1'b1) begin
      bad++;
      $display("FAIL set_wins: got msip=%0b want 1", csr_mip[3]);
    end
    sw_clr = 1; sw_hart = 3'd4;
    cyc();
    idle();
    csr_mstatus_mie = '1;
  endtask

`ifdef PITO_IRQ_TIMER_EN
  task automatic test_timer();
    rst = 1; idle();
    cyc();
    @(negedge clk) rst = 0;
    cmp_we = 1; cmp_hart = 3'd1; cmp_hi = 1; cmp_wdata = 32'd0;
    cyc();
    cmp_hi = 0; cmp_wdata = 32'd20;
    cyc();
    idle();
    csr_mie[1*32 +: 32] = 32'h0000_0080; hart_sel = 3'd1;
    for (int i = 0; i < 30; i++) begin
      cyc();
      total++;
      if (irq_valid !== ((mtime - 64'd1) >= 64'd20) ||
          irq_cause !== (((mtime - 64'd1) >= 64'd20) ? 32'h8000_0007 : 32'd0)) begin
        bad++;
        $display("FAIL timer_cmp: mtime=%0d got v=%0b c=%h", mtime, irq_valid, irq_cause);
      end
    end
    cmp_we = 1; cmp_hi = 0; cmp_wdata = 32'hFFFF_FFFF;
    cyc();
    idle();
    cyc();
    total++;
    if (irq_valid !== 1'b0 || csr_mip[7] !== 1'b0) begin
      bad++;
      $display("FAIL timer_rewrite: got v=%0b mtip=%0b want 0/0", irq_valid, csr_mip[7]);
    end
  endtask
`else
  task automatic test_no_timer();
    csr_mie = '1; csr_mstatus_mie = '1; hart_sel = 3'd1;
    cmp_we = 1; cmp_hart = 3'd1; cmp_hi = 0; cmp_wdata = 32'd0;
    cyc();
    cmp_hi = 1;
    cyc();
    idle();
    for (int i = 0; i < 20; i++) begin
      cyc();
      total++;
      if (irq_cause === 32'h8000_0007 || csr_mip[7] !== 1'b0 || mtime !== 64'd0) begin
        bad++;
        $display("FAIL no_timer: got c=%h mtip=%0b mtime=%0d want no cause 7, mtime 0", irq_cause, csr_mip[7], mtime);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      hart_sel = 3'($urandom_range(0, NH - 1));
      for (int h = 0; h < NH; h++) begin
        if ($urandom_range(0, 7) == 0) ext_irq[h] = ~ext_irq[h];
        if ($urandom_range(0, 3) == 0) mvu_irq[h] = ~mvu_irq[h];
        if (i % 100 == 0) csr_mie[h*32 +: 32] = $urandom;
      end
      csr_mstatus_mie = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      sw_set = ($urandom_range(0, 7) == 0);
      sw_clr = ($urandom_range(0, 7) == 0);
      sw_hart = 3'($urandom_range(0, NH - 1));
      irq_ack = ($urandom_range(0, 3) == 0);
      irq_ack_hart = 3'($urandom_range(0, NH - 1));
      irq_ack_code = 5'(PRIO[$urandom_range(0, 3)]);
      cmp_we = ($urandom_range(0, 15) == 0);
      cmp_hart = 3'($urandom_range(0, NH - 1));
      cmp_hi = ($urandom_range(0, 3) == 0);
      cmp_wdata = cmp_hi ? 32'd0 : 32'($urandom_range(0, 3000));
      cyc();
      total++;
      if ({irq_valid, irq_hart, irq_cause, csr_mip, mtime} !== {m_valid, m_hart, m_cause, m_mip, m_mtime}) begin
        bad++;
        $display("FAIL random_%0d: got v=%0b h=%0d c=%h mip=%h t=%0d want v=%0b h=%0d c=%h mip=%h t=%0d",
                 i, irq_valid, irq_hart, irq_cause, csr_mip, mtime, m_valid, m_hart, m_cause, m_mip, m_mtime);
      end
      if (i == 700) begin
        #2 rst = 1;
        #1;
        total++;
        if ({irq_valid, irq_hart, irq_cause, csr_mip} !== '0 || mtime !== 64'd0) begin
          bad++;
          $display("FAIL async_reset: got v=%0b h=%0d c=%h mip=%h t=%0d want all 0",
                   irq_valid, irq_hart, irq_cause, csr_mip, mtime);
        end
        @(negedge clk) rst = 0;
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_sw();
    test_mvu_ext();
    test_mask();
`ifdef PITO_IRQ_TIMER_EN
    test_timer();
`else
    test_no_timer();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
